gpu_mem_arbiter: RTL and testbench

// Shares one byte-wide Avalon-MM master port among NUM_MASTERS gpu_controller m1 ports (one per screen tile).

---
 rtl/gpu_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_gpu_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// gpu_mem_arbiter
// Shares one byte-wide Avalon-MM master port among NUM_MASTERS gpu_controller
// ports (one per screen tile). One transaction is in flight at a time and
// masters are served round-robin.
//
// Each controller sees waitrequest held high until its transaction has
// completed downstream. It then sees a single cycle of waitrequest low, with
// readdatavalid high for reads.
//
// Ports
//   clock, reset       clock; asynchronous active-high reset
//   m_address          per-master address, master k at [k*ADDR_BITS +: ADDR_BITS]
//   m_writedata        per-master write data, master k at [k*DATA_BITS +: DATA_BITS]
//   m_write, m_read    per-master request strobes (read wins if both set)
//   m_waitrequest      per-master stall, low for one cycle on completion
//   m_readdata         latched read data, shared by all masters
//   m_readdatavalid    per-master read completion strobe
//   s_*                downstream Avalon-MM master port (pipelined reads)
//   busy               high whenever the arbiter is not idle
//   grant              index of the current / last granted master
// -----------------------------------------------------------------------------
module gpu_mem_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_BITS   = 32,
   parameter int DATA_BITS   = 8,
   parameter int MASTER_BITS = $clog2(NUM_MASTERS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_MASTERS*ADDR_BITS-1:0] m_address,
   input  logic [NUM_MASTERS*DATA_BITS-1:0] m_writedata,
   input  logic [NUM_MASTERS-1:0]           m_write,
   input  logic [NUM_MASTERS-1:0]           m_read,
   output logic [NUM_MASTERS-1:0]           m_waitrequest,
   output logic [DATA_BITS-1:0]             m_readdata,
   output logic [NUM_MASTERS-1:0]           m_readdatavalid,
   output logic [ADDR_BITS-1:0]             s_address,
   output logic [DATA_BITS-1:0]             s_writedata,
   output logic                             s_write,
   output logic                             s_read,
   input  logic                             s_waitrequest,
   input  logic [DATA_BITS-1:0]             s_readdata,
   input  logic                             s_readdatavalid,
   output logic                             busy,
   output logic [MASTER_BITS-1:0]           grant
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [MASTER_BITS-1:0] grant_reg, grant_next;
   logic [MASTER_BITS-1:0] rr_ptr_reg, rr_ptr_next;
   logic [ADDR_BITS-1:0]   addr_reg, addr_next;
   logic [DATA_BITS-1:0]   wdata_reg, wdata_next;
   logic                   cmd_read_reg, cmd_read_next;
   logic [DATA_BITS-1:0]   rdata_reg, rdata_next;

   logic [NUM_MASTERS-1:0] request;
   logic                   pick_valid;
   logic [MASTER_BITS-1:0] pick_idx;
   logic [MASTER_BITS:0]   scan_sum;

   genvar gi;

   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_request
         assign request[gi] = m_read[gi] | m_write[gi];
      end
   endgenerate

   // Round-robin pick: the first requester at or above rr_ptr, wrapping.
   // The loop runs from the farthest offset down to offset 0, so the
   // requester nearest the pointer is the last one assigned and wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_sum   = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         scan_sum = {1'b0, rr_ptr_reg} + (MASTER_BITS + 1)'(i);
         if (scan_sum >= (MASTER_BITS + 1)'(NUM_MASTERS)) begin
            scan_sum = scan_sum - (MASTER_BITS + 1)'(NUM_MASTERS);
         end
         if (request[scan_sum[MASTER_BITS-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_sum[MASTER_BITS-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         cmd_read_reg <= 1'b0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         cmd_read_reg <= cmd_read_next;
         rdata_reg    <= rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      cmd_read_next = cmd_read_reg;
      rdata_next    = rdata_reg;
      s_read        = 1'b0;
      s_write       = 1'b0;

      case (state_reg)
         IDLE: begin
            // The command is snapshotted here. Later changes by the master
            // cannot alter the transaction in flight.
            if (pick_valid) begin
               grant_next    = pick_idx;
               addr_next     = m_address[pick_idx*ADDR_BITS +: ADDR_BITS];
               wdata_next    = m_writedata[pick_idx*DATA_BITS +: DATA_BITS];
               cmd_read_next = m_read[pick_idx];
               state_next    = ISSUE;
            end
         end
         ISSUE: begin
            s_read  = cmd_read_reg;
            s_write = ~cmd_read_reg;
            if (!s_waitrequest) begin
               state_next = cmd_read_reg ? WAIT_DATA : RESP;
            end
         end
         WAIT_DATA: begin
            if (s_readdatavalid) begin
               rdata_next = s_readdata;
               state_next = RESP;
            end
         end
         RESP: begin
            // Arbitration resumes only from IDLE on the next cycle. With the
            // pointer already past the served master, that master cannot jump
            // ahead of another waiting requester.
            if (grant_reg == MASTER_BITS'(NUM_MASTERS - 1)) begin
               rr_ptr_next = '0;
            end else begin
               rr_ptr_next = grant_reg + MASTER_BITS'(1);
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The read strobe is gated with the live m_read. A master that dropped its
   // request mid-transaction still gets the waitrequest pulse but no data.
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master_resp
         logic served;
         assign served              = (state_reg == RESP) && (grant_reg == MASTER_BITS'(gi));
         assign m_waitrequest[gi]   = ~served;
         assign m_readdatavalid[gi] = served & cmd_read_reg & m_read[gi];
      end
   endgenerate

   assign s_address   = addr_reg;
   assign s_writedata = wdata_reg;
   assign m_readdata  = rdata_reg;
   assign busy        = (state_reg != IDLE);
   assign grant       = grant_reg;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
module tb_gpu_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 8;
   localparam int MB = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [N*AW-1:0]   m_address;
   logic [N*DW-1:0]   m_writedata;
   logic [N-1:0]      m_write;
   logic [N-1:0]      m_read;
   logic [N-1:0]      m_waitrequest;
   logic [DW-1:0]     m_readdata;
   logic [N-1:0]      m_readdatavalid;
   logic [AW-1:0]     s_address;
   logic [DW-1:0]     s_writedata;
   logic              s_write;
   logic              s_read;
   logic              s_waitrequest;
   logic [DW-1:0]     s_readdata;
   logic              s_readdatavalid;
   logic              busy;
   logic [MB-1:0]     grant;

   gpu_mem_arbiter #(.NUM_MASTERS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .MASTER_BITS(MB)) dut (
      .clock(clock), .reset(reset),
      .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write), .m_read(m_read),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write), .s_read(s_read),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .busy(busy), .grant(grant)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboards: master-side completions and slave-side commands.
   typedef struct {
      int        master;
      bit        rdv;
      logic [7:0] rdata;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      bit          is_read;
      logic [7:0]  wdata;
   } cmd_t;

   exp_t exp_q[$];
   cmd_t slv_q[$];

   int comp_count  = 0;
   int last_master = -1;

   // Slave model state
   int         stall_cfg = 0;
   int         stall_left = 0;
   int         rd_lat = 1;
   int         rdv_cnt = 0;
   logic [7:0] pend_data = 8'h00;
   int         issue_cnt = 0;
   int         last_issue_cycles = 0;
   int         accept_count = 0;

   function automatic logic [7:0] slave_data(logic [31:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // Slave: stalls stall_cfg cycles per command, returns read data rd_lat cycles after accept.
   always @(negedge clock) begin
      s_readdatavalid = 1'b0;
      if (rdv_cnt != 0) begin
         rdv_cnt--;
         if (rdv_cnt == 0) begin
            s_readdatavalid = 1'b1;
            s_readdata      = pend_data;
         end
      end
      if (!reset && (s_read || s_write)) begin
         issue_cnt++;
         if (slv_q.size() == 0) begin
            check("slave_unexpected_cmd", 64'({s_read, s_write}), 64'd0);
         end else begin
            check("s_address_hold", 64'(s_address), 64'(slv_q[0].addr));
            check("s_cmd", 64'({s_read, s_write}), slv_q[0].is_read ? 64'd2 : 64'd1);
            if (!slv_q[0].is_read) check("s_writedata_hold", 64'(s_writedata), 64'(slv_q[0].wdata));
         end
         if (stall_left > 0) begin
            s_waitrequest = 1'b1;
            stall_left--;
         end else begin
            s_waitrequest = 1'b0;
            if (s_read) begin
               rdv_cnt   = rd_lat;
               pend_data = slave_data(s_address);
            end
            last_issue_cycles = issue_cnt;
            issue_cnt  = 0;
            stall_left = stall_cfg;
            accept_count++;
            if (slv_q.size() != 0) void'(slv_q.pop_front());
         end
      end else begin
         s_waitrequest = 1'b1;
      end
   end

   // Monitor: one completion per cycle with any waitrequest low.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (m_waitrequest != 4'hF) begin
            comp_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 64'(m_waitrequest), 64'hF);
            end else begin
               e = exp_q.pop_front();
               last_master = e.master;
               check("cmp_waitrequest", 64'(m_waitrequest), 64'(~(4'b0001 << e.master) & 4'hF));
               check("cmp_readdatavalid", 64'(m_readdatavalid), e.rdv ? 64'(4'b0001 << e.master) : 64'd0);
               check("cmp_grant", 64'(grant), 64'(e.master));
               if (e.rdv) check("cmp_readdata", 64'(m_readdata), 64'(e.rdata));
               $display("txn: master=%0d grant=%0d waitreq=%b rdv=%b rdata=0x%02h",
                        e.master, grant, m_waitrequest, m_readdatavalid, m_readdata);
            end
         end else if (m_readdatavalid != 4'h0) begin
            check("stray_readdatavalid", 64'(m_readdatavalid), 64'd0);
         end
      end
   end

   task automatic wait_comp(output int who);
      int target;
      target = comp_count + 1;
      for (int i = 0; i < 200 && comp_count < target; i++) begin
         @(negedge clock); #1;
      end
      if (comp_count < target) check("completion_timeout", 64'(comp_count), 64'(target));
      who = last_master;
   endtask

   task automatic wait_accept();
      int target;
      target = accept_count + 1;
      for (int i = 0; i < 200 && accept_count < target; i++) begin
         @(negedge clock); #1;
      end
      if (accept_count < target) check("accept_timeout", 64'(accept_count), 64'(target));
   endtask

   task automatic push_read(int m, logic [31:0] a);
      exp_t e;
      cmd_t c;
      e.master = m; e.rdv = 1'b1; e.rdata = slave_data(a);
      c.addr = a; c.is_read = 1'b1; c.wdata = 8'h00;
      exp_q.push_back(e);
      slv_q.push_back(c);
      m_address[m*AW +: AW] = a;
      m_read[m] = 1'b1;
   endtask

   task automatic do_reset(logic [3:0] req);
      @(negedge clock); #1;
      reset = 1'b1;
      exp_q.delete();
      slv_q.delete();
      stall_cfg = 0; stall_left = 0; rd_lat = 1;
      m_read = req; m_write = '0;
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      int          master;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
      int          stall;
      int          lat;
      bit          drop;
   } vec_t;

   task automatic run_vec(vec_t v);
      exp_t e;
      cmd_t c;
      int   who;
      stall_cfg = v.stall; stall_left = v.stall; rd_lat = v.lat;
      e.master = v.master; e.rdv = v.rd && !v.drop; e.rdata = slave_data(v.addr);
      c.addr = v.addr; c.is_read = v.rd; c.wdata = v.wdata;
      exp_q.push_back(e);
      slv_q.push_back(c);
      m_address[v.master*AW +: AW]   = v.addr;
      m_writedata[v.master*DW +: DW] = v.wdata;
      m_read[v.master]  = v.rd;
      m_write[v.master] = v.wr;
      if (v.drop) begin
         wait_accept();
         @(negedge clock); #1;
         m_read[v.master] = 1'b0;
      end
      wait_comp(who);
      m_read[v.master]  = 1'b0;
      m_write[v.master] = 1'b0;
      check("issue_cycles", 64'(last_issue_cycles), 64'(v.stall + 1));
      @(negedge clock); #1;
      check("busy_after", 64'(busy), 64'd0);
      check("waitrequest_after", 64'(m_waitrequest), 64'hF);
   endtask

   // Masters 0 and 1 request together; pointer at 1 means 1 is served first.
   task automatic pair_after_ptr1();
      int who;
      push_read(1, 32'h0000_0011);
      push_read(0, 32'h0000_0022);
      wait_comp(who);
      m_read[1] = 1'b0;
      wait_comp(who);
      m_read[0] = 1'b0;
      @(negedge clock); #1;
   endtask

   vec_t vecs[7];

   initial begin
      int who;
      vecs[0] = '{2, 1'b1, 1'b0, 32'h0000_0100, 8'h00, 0, 2, 1'b0};
      vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_2000, 8'h3C, 5, 1, 1'b0};
      vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0010, 8'h00, 3, 1, 1'b0};
      vecs[3] = '{3, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF, 0, 1, 1'b0};
      vecs[4] = '{3, 1'b1, 1'b0, 32'hABCD_00E7, 8'h00, 2, 4, 1'b0};
      vecs[5] = '{1, 1'b1, 1'b1, 32'h0000_0044, 8'h77, 1, 1, 1'b0};
      vecs[6] = '{0, 1'b1, 1'b0, 32'h0000_0033, 8'h00, 0, 3, 1'b1};

      reset = 1'b1;
      m_address = '0; m_writedata = '0; m_read = '0; m_write = '0;
      s_waitrequest = 1'b1; s_readdata = '0; s_readdatavalid = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("rst_waitrequest", 64'(m_waitrequest), 64'hF);
      check("rst_readdatavalid", 64'(m_readdatavalid), 64'd0);
      check("rst_readdata", 64'(m_readdata), 64'd0);
      check("rst_s_cmd", 64'({s_read, s_write}), 64'd0);
      check("rst_s_address", 64'(s_address), 64'd0);
      check("rst_s_writedata", 64'(s_writedata), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      @(negedge clock); #1;

      foreach (vecs[i]) run_vec(vecs[i]);
      check("readdata_hold", 64'(m_readdata), 64'(slave_data(32'h33)));

      // Dropped read on master 0 still advanced the pointer to 1.
      pair_after_ptr1();

      // Reset in WAIT_DATA; the late readdatavalid must be ignored.
      stall_cfg = 0; stall_left = 0; rd_lat = 6;
      push_read(2, 32'h0000_0099);
      wait_accept();
      @(negedge clock); #1;
      reset = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_waitrequest", 64'(m_waitrequest), 64'hF);
      check("midrst_readdata", 64'(m_readdata), 64'd0);
      check("midrst_grant", 64'(grant), 64'd0);
      check("midrst_s_address", 64'(s_address), 64'd0);
      m_read = '0;
      exp_q.delete();
      slv_q.delete();
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 20 && rdv_cnt != 0; i++) begin
         @(negedge clock); #1;
      end
      @(negedge clock); #1;
      check("midrst_late_rdv_readdata", 64'(m_readdata), 64'd0);
      check("midrst_late_rdv_busy", 64'(busy), 64'd0);

      // Round robin: all four hold reads from reset; order 0,1,2,3,0.
      do_reset(4'h0);
      for (int k = 0; k < 5; k++) begin
         exp_t e;
         cmd_t c;
         e.master = k % 4; e.rdv = 1'b1; e.rdata = slave_data(32'h40 + 32'(k % 4));
         c.addr = 32'h40 + 32'(k % 4); c.is_read = 1'b1; c.wdata = 8'h00;
         exp_q.push_back(e);
         slv_q.push_back(c);
      end
      for (int k = 0; k < 4; k++) m_address[k*AW +: AW] = 32'h40 + 32'(k);
      m_read = 4'hF;
      for (int k = 0; k < 5; k++) wait_comp(who);
      m_read = 4'h0;
      @(negedge clock); #1;
      check("rr_all_served", 64'(comp_count), 64'(comp_count));
      check("rr_queue_empty", 64'(exp_q.size()), 64'd0);

      // Pointer wrap: master 3 first, master 0 joins while 3 is in flight.
      do_reset(4'h0);
      push_read(3, 32'h0000_0077);
      @(negedge clock); #1;
      push_read(0, 32'h0000_0088);
      wait_comp(who);
      m_read[3] = 1'b0;
      wait_comp(who);
      m_read[0] = 1'b0;
      @(negedge clock); #1;
      pair_after_ptr1();
      check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
